// File: rtl/j_pulse_timer.sv
// j_pulse_timer: pulse-driven down-counter with reload, one-shot/periodic modes,
// latched interrupt request and the pulse generator's stop control.
// Optional feature macro: JPT_OVERRUN_EN (sticky overrun flag). When undefined,
// overrun is tied low and no overrun register exists.
module j_pulse_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             pulse,
    input  logic [WIDTH-1:0] reload,
    input  logic             reload_wr,
    input  logic             run,
    input  logic             oneshot,
    input  logic             int_ack,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             int_req,
    output logic             stop,
    output logic             overrun
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             int_req_q, int_req_d;
    logic             stop_q, stop_d;
    logic             expiry;

    // Next-state, counter and reload-shadow update.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_wr ? reload : reload_q;
        expiry   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (reload_wr) count_d = reload;
                if (run) state_d = StRun;
            end
            StRun: begin
                // Dropping run takes priority; a pulse in that cycle is discarded.
                if (!run) begin
                    state_d = StIdle;
                end else if (pulse) begin
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end else begin
                        expiry = 1'b1;
                        if (oneshot) begin
                            state_d = StHalt;
                        end else begin
                            // reload_d already reflects a same-cycle reload write.
                            count_d = reload_d;
                        end
                    end
                end
            end
            StHalt: begin
                if (reload_wr) count_d = reload;
                if (!run) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        tick_d = expiry;
        // Set beats acknowledge on a tie.
        if (expiry) begin
            int_req_d = 1'b1;
        end else if (int_ack) begin
            int_req_d = 1'b0;
        end else begin
            int_req_d = int_req_q;
        end

        // stop tracks the state being entered, so it flips on the same edge.
        stop_d = (state_d != StRun);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q   <= StIdle;
            reload_q  <= '0;
            count_q   <= '0;
            tick_q    <= 1'b0;
            int_req_q <= 1'b0;
            stop_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            reload_q  <= reload_d;
            count_q   <= count_d;
            tick_q    <= tick_d;
            int_req_q <= int_req_d;
            stop_q    <= stop_d;
        end
    end

`ifdef JPT_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Overrun: expiry while a previous request is still unacknowledged.
    always_comb begin
        overrun_d = overrun_q;
        if (expiry && int_req_q && !int_ack) begin
            overrun_d = 1'b1;
        end else if (int_ack) begin
            overrun_d = 1'b0;
        end
    end

    // Sticky overrun register.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    assign count   = count_q;
    assign tick    = tick_q;
    assign int_req = int_req_q;
    assign stop    = stop_q;

endmodule

// File: tb/tb_j_pulse_timer.sv
// Directed self-checking bench for j_pulse_timer. Inputs change 1 time unit after
// a rising edge; outputs are sampled at the same point, reflecting that edge.
module tb_j_pulse_timer;

    localparam int unsigned WIDTH = 16;
`ifdef JPT_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic             sys_clk = 1'b0;
    logic             reset = 1'b0;
    logic             pulse = 1'b0;
    logic [WIDTH-1:0] reload = '0;
    logic             reload_wr = 1'b0;
    logic             run = 1'b0;
    logic             oneshot = 1'b0;
    logic             int_ack = 1'b0;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             int_req;
    logic             stop;
    logic             overrun;

    int n_cmp = 0;
    int n_bad = 0;

    j_pulse_timer #(.WIDTH(WIDTH)) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .pulse     (pulse),
        .reload    (reload),
        .reload_wr (reload_wr),
        .run       (run),
        .oneshot   (oneshot),
        .int_ack   (int_ack),
        .count     (count),
        .tick      (tick),
        .int_req   (int_req),
        .stop      (stop),
        .overrun   (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (count !== 16'd0) begin n_bad++; $display("FAIL rst_count act=%0d exp=0", count); end
        n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL rst_tick act=%b exp=0", tick); end
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL rst_int_req act=%b exp=0", int_req); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun act=%b exp=0", overrun); end
        n_cmp++; if (stop !== 1'b1) begin n_bad++; $display("FAIL rst_stop act=%b exp=1", stop); end
    endtask

    task automatic test_periodic();
        logic [WIDTH-1:0] exp_cnt [3] = '{16'd2, 16'd1, 16'd0};
        reload = 16'd3; reload_wr = 1'b1;
        step();
        reload_wr = 1'b0;
        n_cmp++; if (count !== 16'd3) begin n_bad++; $display("FAIL per_load act=%0d exp=3", count); end
        // Pulse in the cycle run rises is ignored.
        run = 1'b1; pulse = 1'b1;
        step();
        n_cmp++; if (stop !== 1'b0) begin n_bad++; $display("FAIL per_stop act=%b exp=0", stop); end
        n_cmp++; if (count !== 16'd3) begin n_bad++; $display("FAIL per_first_pulse act=%0d exp=3", count); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (count !== exp_cnt[i] || tick !== 1'b0) begin
                n_bad++;
                $display("FAIL per_dec%0d act=%0d/%b exp=%0d/0", i, count, tick, exp_cnt[i]);
            end
        end
        step();
        pulse = 1'b0;
        n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL per_tick act=%b exp=1", tick); end
        n_cmp++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL per_int act=%b exp=1", int_req); end
        n_cmp++; if (count !== 16'd3) begin n_bad++; $display("FAIL per_reload act=%0d exp=3", count); end
        step();
        n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL per_tick_off act=%b exp=0", tick); end
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        n_cmp++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL per_ack act=%b exp=0", int_req); end
    endtask

    task automatic test_oneshot();
        run = 1'b0;
        step();
        n_cmp++; if (stop !== 1'b1) begin n_bad++; $display("FAIL os_idle_stop act=%b exp=1", stop); end
        oneshot = 1'b1; reload = 16'd1; reload_wr = 1'b1;
        step();
        reload_wr = 1'b0; run = 1'b1;
        step();
        pulse = 1'b1;
        step();
        n_cmp++; if (count !== 16'd0) begin n_bad++; $display("FAIL os_dec act=%0d exp=0", count); end
        step();
        n_cmp++;
        if (tick !== 1'b1 || int_req !== 1'b1 || stop !== 1'b1 || count !== 16'd0) begin
            n_bad++;
            $display("FAIL os_expire act=tick%b int%b stop%b cnt%0d exp=1 1 1 0", tick, int_req, stop, count);
        end
        step();
        step();
        pulse = 1'b0;
        n_cmp++;
        if (tick !== 1'b0 || count !== 16'd0 || stop !== 1'b1) begin
            n_bad++;
            $display("FAIL os_halted act=tick%b cnt%0d stop%b exp=0 0 1", tick, count, stop);
        end
        run = 1'b0;
        step();
        reload_wr = 1'b1;
        step();
        reload_wr = 1'b0; run = 1'b1;
        step();
        n_cmp++;
        if (stop !== 1'b0 || count !== 16'd1) begin
            n_bad++;
            $display("FAIL os_rearm act=stop%b cnt%0d exp=0 1", stop, count);
        end
        pulse = 1'b1;
        step();
        step();
        pulse = 1'b0;
        n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL os_rearm_tick act=%b exp=1", tick); end
        run = 1'b0; oneshot = 1'b0; int_ack = 1'b1;
        step();
        int_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        reload = 16'd0; reload_wr = 1'b1;
        step();
        reload_wr = 1'b0; run = 1'b1;
        step();
        pulse = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (tick !== 1'b1 || count !== 16'd0) begin
                n_bad++;
                $display("FAIL b2b_tick%0d act=%b/%0d exp=1/0", i, tick, count);
            end
            n_cmp++;
            if (overrun !== ((i >= 1) && OVR_EN)) begin
                n_bad++;
                $display("FAIL b2b_ovr%0d act=%b exp=%b", i, overrun, (i >= 1) && OVR_EN);
            end
        end
        pulse = 1'b0;
        step();
        n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL b2b_tick_end act=%b exp=0", tick); end
    endtask

    task automatic test_ack_race();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        n_cmp++;
        if (int_req !== 1'b0 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_clear act=int%b ovr%b exp=0 0", int_req, overrun);
        end
        pulse = 1'b1;
        step();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        n_cmp++;
        if (int_req !== 1'b1 || tick !== 1'b1 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_tie act=int%b tick%b ovr%b exp=1 1 0", int_req, tick, overrun);
        end
        step();
        pulse = 1'b0;
        n_cmp++; if (overrun !== OVR_EN) begin n_bad++; $display("FAIL ack_ovr_set act=%b exp=%b", overrun, OVR_EN); end
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        n_cmp++;
        if (int_req !== 1'b0 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_lone act=int%b ovr%b exp=0 0", int_req, overrun);
        end
    endtask

    task automatic test_reload_in_run();
        logic [WIDTH-1:0] exp_cnt [5] = '{16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
        run = 1'b0;
        step();
        reload = 16'd5; reload_wr = 1'b1;
        step();
        reload_wr = 1'b0; run = 1'b1;
        step();
        reload = 16'd2; reload_wr = 1'b1;
        step();
        reload_wr = 1'b0;
        n_cmp++; if (count !== 16'd5) begin n_bad++; $display("FAIL rr_hold act=%0d exp=5", count); end
        pulse = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (count !== exp_cnt[i]) begin
                n_bad++;
                $display("FAIL rr_dec%0d act=%0d exp=%0d", i, count, exp_cnt[i]);
            end
        end
        step();
        n_cmp++;
        if (count !== 16'd2 || tick !== 1'b1) begin
            n_bad++;
            $display("FAIL rr_expire act=%0d/%b exp=2/1", count, tick);
        end
        step();
        step();
        // Expiry coinciding with a reload write takes the new value.
        reload = 16'd6; reload_wr = 1'b1;
        step();
        reload_wr = 1'b0; pulse = 1'b0;
        n_cmp++;
        if (count !== 16'd6 || tick !== 1'b1) begin
            n_bad++;
            $display("FAIL rr_same_cycle act=%0d/%b exp=6/1", count, tick);
        end
    endtask

    task automatic test_reset_mid();
        run = 1'b0;
        step();
        reload = 16'd7; reload_wr = 1'b1;
        step();
        reload_wr = 1'b0;
        n_cmp++;
        if (count !== 16'd7 || int_req !== 1'b1) begin
            n_bad++;
            $display("FAIL rm_pre act=%0d/%b exp=7/1", count, int_req);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if (count !== 16'd0 || tick !== 1'b0 || int_req !== 1'b0 || overrun !== 1'b0 || stop !== 1'b1) begin
            n_bad++;
            $display("FAIL rm_post act=cnt%0d tick%b int%b ovr%b stop%b exp=0 0 0 0 1",
                     count, tick, int_req, overrun, stop);
        end
        // Shadow reload cleared too: second expiry reloads 0, not 7.
        run = 1'b1;
        step();
        pulse = 1'b1;
        step();
        step();
        pulse = 1'b0;
        n_cmp++;
        if (count !== 16'd0 || tick !== 1'b1) begin
            n_bad++;
            $display("FAIL rm_shadow act=%0d/%b exp=0/1", count, tick);
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_back_to_back();
        test_ack_race();
        test_reload_in_run();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
